// File: rtl/bf_prog_mem.sv
// Brainfuck program memory: loads an ASCII program stream, encodes it into
// 3-bit opcodes, precomputes matching-bracket addresses with a bracket stack
// and serves registered fetches of opcode, jump target and overrun flag.
module bf_prog_mem #(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_done,
  output logic [1:0]        ld_err,
  output logic [ADDR_W:0]   prog_len,
  input  logic [ADDR_W-1:0] addr,
  output logic [2:0]        code,
  output logic [ADDR_W-1:0] jump,
  output logic              rom_overrun
);

  localparam int LEN_W  = ADDR_W + 1;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SP_W   = $clog2(STACK_DEPTH + 1);
  localparam int SIDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
  localparam logic [SP_W-1:0]  SP_FULL = SP_W'(STACK_DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FIXUP = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [1:0] E_LONG  = 2'd1;
  localparam logic [1:0] E_CLOSE = 2'd2;
  localparam logic [1:0] E_OPEN  = 2'd3;

  localparam logic [2:0] OP_OPEN  = 3'b011;
  localparam logic [2:0] OP_CLOSE = 3'b010;

  logic [2:0]        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [1:0]        err_q, err_d;
  logic [ADDR_W-1:0] fix_a_q, fix_a_d;
  logic [ADDR_W-1:0] fix_b_q, fix_b_d;
  logic              fix_last_q, fix_last_d;
  logic [2:0]        code_q, code_d;
  logic [ADDR_W-1:0] jump_q, jump_d;
  logic              ovr_q, ovr_d;

  logic [2:0]        code_mem  [DEPTH];
  logic [ADDR_W-1:0] jump_mem  [DEPTH];
  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

  logic              is_bf;
  logic [2:0]        opc;
  logic              code_we, jump_we, stack_we;
  logic [IDX_W-1:0]  jump_waddr;
  logic [ADDR_W-1:0] jump_wdata;
  logic [IDX_W-1:0]  wr_idx, rd_idx, fix_idx;
  logic [SIDX_W-1:0] push_idx, pop_idx;
  logic [ADDR_W-1:0] stack_top;

  assign wr_idx    = len_q[IDX_W-1:0];
  assign rd_idx    = addr[IDX_W-1:0];
  assign fix_idx   = fix_a_q[IDX_W-1:0];
  assign push_idx  = sp_q[SIDX_W-1:0];
  assign pop_idx   = push_idx - SIDX_W'(1);
  assign stack_top = stack_mem[pop_idx];

  // Translate the incoming ASCII byte into an opcode; other bytes are filler.
  always_comb begin
    is_bf = 1'b1;
    opc   = 3'b000;
    case (ld_data)
      8'h2B:   opc = 3'b111;
      8'h2D:   opc = 3'b110;
      8'h3E:   opc = 3'b101;
      8'h3C:   opc = 3'b100;
      8'h5B:   opc = 3'b011;
      8'h5D:   opc = 3'b010;
      8'h2E:   opc = 3'b001;
      8'h2C:   opc = 3'b000;
      default: is_bf = 1'b0;
    endcase
  end

  // Loader state machine: stores opcodes, tracks brackets, patches jumps.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    sp_d       = sp_q;
    err_d      = err_q;
    fix_a_d    = fix_a_q;
    fix_b_d    = fix_b_q;
    fix_last_d = fix_last_q;
    code_we    = 1'b0;
    jump_we    = 1'b0;
    stack_we   = 1'b0;
    jump_waddr = wr_idx;
    jump_wdata = '0;
    case (state_q)
      S_LOAD: begin
        if (ld_valid) begin
          if (is_bf) begin
            if (len_q == DEPTH_L) begin
              state_d = S_ERR;
              err_d   = E_LONG;
            end else if (opc == OP_OPEN && sp_q == SP_FULL) begin
              state_d = S_ERR;
              err_d   = E_OPEN;
            end else if (opc == OP_CLOSE && sp_q == '0) begin
              state_d = S_ERR;
              err_d   = E_CLOSE;
            end else begin
              code_we = 1'b1;
              jump_we = 1'b1;
              len_d   = len_q + LEN_W'(1);
              if (opc == OP_CLOSE) begin
                sp_d       = sp_q - SP_W'(1);
                jump_wdata = stack_top;
                fix_a_d    = stack_top;
                fix_b_d    = len_q[ADDR_W-1:0];
                fix_last_d = ld_last;
                state_d    = S_FIXUP;
              end else begin
                if (opc == OP_OPEN) begin
                  stack_we = 1'b1;
                  sp_d     = sp_q + SP_W'(1);
                end
                if (ld_last) begin
                  state_d = (sp_d == '0) ? S_DONE : S_ERR;
                  err_d   = (sp_d == '0) ? 2'd0 : E_OPEN;
                end
              end
            end
          end else if (ld_last) begin
            state_d = (sp_q == '0) ? S_DONE : S_ERR;
            err_d   = (sp_q == '0) ? 2'd0 : E_OPEN;
          end
        end
      end
      S_FIXUP: begin
        jump_we    = 1'b1;
        jump_waddr = fix_idx;
        jump_wdata = fix_b_q;
        if (fix_last_q) begin
          state_d = (sp_q == '0) ? S_DONE : S_ERR;
          err_d   = (sp_q == '0) ? 2'd0 : E_OPEN;
        end else begin
          state_d = S_LOAD;
        end
      end
      default: ;
    endcase
    if (ld_start) begin
      state_d  = S_LOAD;
      len_d    = '0;
      sp_d     = '0;
      err_d    = 2'd0;
      code_we  = 1'b0;
      jump_we  = 1'b0;
      stack_we = 1'b0;
    end
  end

  // Fetch port: only a completed program below its length is visible.
  always_comb begin
    code_d = 3'b000;
    jump_d = '0;
    ovr_d  = 1'b1;
    if (state_q == S_DONE && {1'b0, addr} < len_q) begin
      code_d = code_mem[rd_idx];
      jump_d = jump_mem[rd_idx];
      ovr_d  = 1'b0;
    end
  end

  // Control and fetch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      sp_q       <= '0;
      err_q      <= 2'd0;
      fix_a_q    <= '0;
      fix_b_q    <= '0;
      fix_last_q <= 1'b0;
      code_q     <= 3'b000;
      jump_q     <= '0;
      ovr_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      sp_q       <= sp_d;
      err_q      <= err_d;
      fix_a_q    <= fix_a_d;
      fix_b_q    <= fix_b_d;
      fix_last_q <= fix_last_d;
      code_q     <= code_d;
      jump_q     <= jump_d;
      ovr_q      <= ovr_d;
    end
  end

  // Program, jump and bracket-stack storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (code_we)  code_mem[wr_idx]     <= opc;
    if (jump_we)  jump_mem[jump_waddr] <= jump_wdata;
    if (stack_we) stack_mem[push_idx]  <= len_q[ADDR_W-1:0];
  end

  assign ld_ready    = (state_q == S_LOAD);
  assign ld_done     = (state_q == S_DONE);
  assign ld_err      = err_q;
  assign prog_len    = len_q;
  assign code        = code_q;
  assign jump        = jump_q;
  assign rom_overrun = ovr_q;

endmodule

// File: tb/tb_bf_prog_mem.sv
// Scoreboard bench for bf_prog_mem: a full-size instance and a small one
// (DEPTH=4, STACK_DEPTH=2), checked against a string-level loader model.
module tb_bf_prog_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       ld_start [2];
  logic       ld_valid [2];
  logic [7:0] ld_data  [2];
  logic       ld_last  [2];
  logic       ld_ready [2];
  logic       ld_done  [2];
  logic [1:0] ld_err   [2];
  logic [8:0] prog_len [2];
  logic [7:0] addr     [2];
  logic [2:0] code     [2];
  logic [7:0] jump     [2];
  logic       rom_overrun [2];

  bf_prog_mem #(.DEPTH(256), .ADDR_W(8), .STACK_DEPTH(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start[0]), .ld_valid(ld_valid[0]),
    .ld_data(ld_data[0]), .ld_last(ld_last[0]), .ld_ready(ld_ready[0]),
    .ld_done(ld_done[0]), .ld_err(ld_err[0]), .prog_len(prog_len[0]),
    .addr(addr[0]), .code(code[0]), .jump(jump[0]), .rom_overrun(rom_overrun[0]));

  bf_prog_mem #(.DEPTH(4), .ADDR_W(8), .STACK_DEPTH(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start[1]), .ld_valid(ld_valid[1]),
    .ld_data(ld_data[1]), .ld_last(ld_last[1]), .ld_ready(ld_ready[1]),
    .ld_done(ld_done[1]), .ld_err(ld_err[1]), .prog_len(prog_len[1]),
    .addr(addr[1]), .code(code[1]), .jump(jump[1]), .rom_overrun(rom_overrun[1]));

  typedef struct { int done; int err; int len; } ld_exp_t;
  typedef struct { int addr; int code; int jump; int ovr; } fe_exp_t;

  ld_exp_t ldq0[$];
  ld_exp_t ldq1[$];
  fe_exp_t feq[$];

  int  checks = 0;
  int  errors = 0;
  byte progQ[$];
  int  m_code [256];
  int  m_jump [256];
  int  m_len0;
  int  m_done0;
  logic fe_issue = 1'b0;
  logic fe_pend  = 1'b0;
  bit   fin_prev [2];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int opcodeOf(input byte c);
    case (c)
      "+": return 7;
      "-": return 6;
      ">": return 5;
      "<": return 4;
      "[": return 3;
      "]": return 2;
      ".": return 1;
      ",": return 0;
      default: return -1;
    endcase
  endfunction

  // Reference loader: walk the program text with an address stack.
  task automatic modelLoad(input bit lastFinal, input int depth, input int sdepth, input bit fill,
                           output int len, output int done, output int err,
                           output int termIdx, output int termDelay);
    int stk[$];
    int a;
    len = 0; done = 0; err = 0; termIdx = -1; termDelay = 1;
    for (int i = 0; i < progQ.size(); i++) begin
      byte c;
      bit  last;
      c = progQ[i];
      last = lastFinal && (i == progQ.size() - 1);
      if (opcodeOf(c) >= 0) begin
        if (len == depth) begin err = 1; termIdx = i; break; end
        if (c == "[" && stk.size() == sdepth) begin err = 3; termIdx = i; break; end
        if (c == "]" && stk.size() == 0) begin err = 2; termIdx = i; break; end
        if (fill) begin
          m_code[len] = opcodeOf(c);
          m_jump[len] = 0;
        end
        if (c == "[") stk.push_back(len);
        if (c == "]") begin
          a = stk.pop_back();
          if (fill) begin
            m_jump[a]   = len;
            m_jump[len] = a;
          end
          if (last) termDelay = 2;
        end
        len++;
      end
      if (last) begin
        termIdx = i;
        if (stk.size() == 0) done = 1; else err = 3;
        break;
      end
    end
  endtask

  task automatic setProg(input string s);
    progQ.delete();
    for (int i = 0; i < s.len(); i++) progQ.push_back(byte'(s[i]));
  endtask

  task automatic startLoad(input int d);
    @(negedge clk);
    ld_start[d] = 1'b1;
    @(posedge clk);
    #1;
    ld_start[d] = 1'b0;
    @(negedge clk);
    checkOutput("start_ready", 32'(ld_ready[d]), 1);
    checkOutput("start_len", 32'(prog_len[d]), 0);
  endtask

  // Present one byte (caller is at a falling edge) and wait for acceptance.
  task automatic sendByte(input int d, input byte b, input bit last, output bit ok);
    ok = 1'b0;
    ld_valid[d] = 1'b1;
    ld_data[d]  = b;
    ld_last[d]  = last;
    for (int t = 0; t < 20; t++) begin
      if (ld_ready[d]) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    ld_valid[d] = 1'b0;
    ld_last[d]  = 1'b0;
    if (!ok) checkOutput("ready_timeout", 32'(ld_ready[d]), 1);
  endtask

  // Model the program in progQ, queue the expected result, then stream it.
  task automatic applyStimulus(input int d, input bit lastFinal);
    int len, done, err, termIdx, termDelay;
    bit ok, prevFix;
    ld_exp_t e;
    modelLoad(lastFinal, (d == 0) ? 256 : 4, (d == 0) ? 16 : 2, d == 0,
              len, done, err, termIdx, termDelay);
    if (d == 0) begin m_len0 = len; m_done0 = done; end
    e.done = done; e.err = err; e.len = len;
    if (termIdx >= 0) begin
      if (d == 0) ldq0.push_back(e); else ldq1.push_back(e);
    end
    startLoad(d);
    prevFix = 1'b0;
    for (int i = 0; i < progQ.size(); i++) begin
      if (prevFix) checkOutput("fixup_ready_high", 32'(ld_ready[d]), 1);
      sendByte(d, progQ[i], lastFinal && (i == progQ.size() - 1), ok);
      if (!ok) break;
      @(negedge clk);
      if (i == termIdx) begin
        if (termDelay == 1) begin
          checkOutput("term_latency", 32'(ld_done[d] || ld_err[d] != 0), 1);
        end else begin
          checkOutput("term_early", 32'(ld_done[d] || ld_err[d] != 0), 0);
          checkOutput("fixup_ready_low", 32'(ld_ready[d]), 0);
          @(negedge clk);
          checkOutput("term_latency", 32'(ld_done[d] || ld_err[d] != 0), 1);
        end
        break;
      end
      if (progQ[i] == "]") begin
        checkOutput("fixup_ready_low", 32'(ld_ready[d]), 0);
        @(negedge clk);
        prevFix = 1'b1;
      end else begin
        prevFix = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  // Sweep fetch addresses over the full-size instance's program.
  task automatic fetchAll();
    fe_exp_t f;
    int n;
    n = m_len0 + 2;
    @(negedge clk);
    for (int k = 0; k < n + 3; k++) begin
      logic [7:0] av;
      av = (k < n) ? 8'(k) : 8'($urandom_range(0, 255));
      addr[0] = av;
      f.addr = int'(av);
      if (m_done0 != 0 && int'(av) < m_len0) begin
        f.code = m_code[av]; f.jump = m_jump[av]; f.ovr = 0;
      end else begin
        f.code = 0; f.jump = 0; f.ovr = 1;
      end
      feq.push_back(f);
      fe_issue = 1'b1;
      @(negedge clk);
    end
    fe_issue = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, 32'(ld_ready[0]), 0);
    checkOutput({tag, "_done"}, 32'(ld_done[0]), 0);
    checkOutput({tag, "_err"}, 32'(ld_err[0]), 0);
    checkOutput({tag, "_len"}, 32'(prog_len[0]), 0);
    checkOutput({tag, "_code"}, 32'(code[0]), 0);
    checkOutput({tag, "_jump"}, 32'(jump[0]), 0);
    checkOutput({tag, "_overrun"}, 32'(rom_overrun[0]), 1);
  endtask

  task automatic randomProgram();
    string ops;
    int n, depthc, r;
    ops = "+-<>.,";
    progQ.delete();
    n = $urandom_range(1, 30);
    depthc = 0;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8) progQ.push_back((r < 4) ? byte'("a") : byte'(" "));
      else if (r < 28 && depthc < 5) begin progQ.push_back(byte'("[")); depthc++; end
      else if (r < 45 && depthc > 0) begin progQ.push_back(byte'("]")); depthc--; end
      else if (r < 47) progQ.push_back(byte'("]"));
      else progQ.push_back(byte'(ops[$urandom_range(0, 5)]));
    end
    if ($urandom_range(0, 3) != 0) begin
      while (depthc > 0) begin progQ.push_back(byte'("]")); depthc--; end
    end
  endtask

  // Completion monitor: a rising done/error flag retires one expected load.
  always @(negedge clk) begin : mon_load
    logic    fin;
    ld_exp_t e;
    for (int d = 0; d < 2; d++) begin
      fin = ld_done[d] || (ld_err[d] != 2'd0);
      if (fin && !fin_prev[d]) begin
        if ((d == 0 && ldq0.size() == 0) || (d == 1 && ldq1.size() == 0)) begin
          checkOutput("unexpected_completion", 32'(d), 32'(-1));
        end else begin
          if (d == 0) e = ldq0.pop_front(); else e = ldq1.pop_front();
          checkOutput("ld_done", 32'(ld_done[d]), 32'(e.done));
          checkOutput("ld_err", 32'(ld_err[d]), 32'(e.err));
          checkOutput("prog_len", 32'(prog_len[d]), 32'(e.len));
        end
      end
      fin_prev[d] = fin;
    end
  end

  // Fetch monitor: each issued address yields a result one cycle later.
  always @(posedge clk) fe_pend <= fe_issue;

  always @(negedge clk) begin : mon_fetch
    fe_exp_t f;
    if (fe_pend) begin
      if (feq.size() == 0) begin
        checkOutput("fetch_unexpected", 32'(code[0]), 32'(-1));
      end else begin
        f = feq.pop_front();
        checkOutput("fetch_code", 32'(code[0]), 32'(f.code));
        checkOutput("fetch_jump", 32'(jump[0]), 32'(f.jump));
        checkOutput("fetch_overrun", 32'(rom_overrun[0]), 32'(f.ovr));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    bit ok;
    for (int d = 0; d < 2; d++) begin
      ld_start[d] = 1'b0; ld_valid[d] = 1'b0; ld_data[d] = 8'h00;
      ld_last[d] = 1'b0; addr[d] = 8'h00;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;
    m_len0 = 0; m_done0 = 0;
    fetchAll();

    setProg("+[-].");   applyStimulus(0, 1'b1); fetchAll();
    setProg("a+ b\n-"); applyStimulus(0, 1'b1); fetchAll();
    setProg("[[]]");    applyStimulus(0, 1'b1); fetchAll();
    setProg("]");       applyStimulus(0, 1'b1); fetchAll();
    setProg("[[");      applyStimulus(0, 1'b1); fetchAll();
    setProg("[[[");     applyStimulus(1, 1'b1);
    setProg("+++++");   applyStimulus(1, 1'b1);
    setProg("+[]-");    applyStimulus(1, 1'b1);

    setProg("++");      applyStimulus(0, 1'b0);
    setProg("-.");      applyStimulus(0, 1'b1); fetchAll();

    startLoad(0);
    @(negedge clk);
    sendByte(0, byte'("["), 1'b0, ok);
    @(negedge clk);
    sendByte(0, byte'("]"), 1'b0, ok);
    rst_n = 1'b0;
    @(negedge clk);
    checkResetValues("fixup_reset");
    rst_n = 1'b1;
    setProg("+.");      applyStimulus(0, 1'b1); fetchAll();

    for (int r = 0; r < 25; r++) begin
      randomProgram();
      applyStimulus(0, $urandom_range(0, 9) != 0);
      fetchAll();
    end
    for (int r = 0; r < 10; r++) begin
      randomProgram();
      applyStimulus(1, 1'b1);
    end

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_drain", 32'(ldq0.size() + ldq1.size() + feq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
